bit_order_deserializer: RTL and testbench

//  Receive end of the ALSU serial bit-order path: assembles a serial bit stream into WIDTH-bit words.

---
 rtl/bit_order_pkg.sv | 30 +++
 rtl/bit_index_map.sv | 34 +++
 rtl/bit_order_deserializer.sv | 190 +++++++++++++++++++
 tb/tb_bit_order_deserializer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bit_order_pkg.sv
// ============================================================================
//  Module      : bit_order_pkg
//  Description : Shared types and constants for the serial bit-order
//                deserializer (FSM state encoding, placement-order codes,
//                bit-counter width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_order_pkg;

    // Receive FSM states; PARITY is only reachable when the parity build is enabled
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Placement order codes for the msb_first control
    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

    // Bit counter width: must hold the values 0..WIDTH
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : bit_order_pkg

`default_nettype wire

// File: rtl/bit_index_map.sv
// ============================================================================
//  Module      : bit_index_map
//  Description : Combinational map from the in-frame bit position (time order)
//                and the frame's placement order to the target word bit index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_index_map
    import bit_order_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = cnt_width(WIDTH)
)
(
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_msb_first,
    output logic [CNT_W-1:0] o_idx
);

    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(WIDTH - 1);

    // MSB-first frames fill the word from the top down
    always_comb begin
        if (i_msb_first == MSB_FIRST) begin
            o_idx = c_LAST_IDX - i_cnt;
        end else begin
            o_idx = i_cnt;
        end
    end

endmodule : bit_index_map

`default_nettype wire

// File: rtl/bit_order_deserializer.sv
// ============================================================================
//  Module      : bit_order_deserializer
//  Description : Assembles a serial bit stream into WIDTH-bit words, placed
//                LSB-first or MSB-first per frame, with a one-deep valid/ready
//                output buffer and an overrun pulse on dropped words.
//                Optional feature macro: BIT_ORDER_PARITY_EN (adds a trailing
//                even-parity bit per frame and drives parity_err).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_order_deserializer
    import bit_order_pkg::*;
#(
    parameter int WIDTH = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_valid,
    input  logic             ser_data,
    input  logic             ser_start,
    input  logic             msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overrun,
    output logic             parity_err
);

    localparam int               CNT_W      = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic               r_msb;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_overrun;

    logic               w_start;
    logic               w_bit;
    logic               w_capture;
    logic               w_complete;
    logic [CNT_W-1:0]   w_map_cnt;
    logic               w_map_msb;
    logic [CNT_W-1:0]   w_bit_idx;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [WIDTH-1:0]   w_word;

    // A qualified start restarts the frame from any state; other valid bits are data
    assign w_start = ser_valid && ser_start;
    assign w_bit   = ser_valid && !ser_start;

    // A start bit is always bit 0 and uses the freshly sampled order
    assign w_map_cnt = w_start ? '0 : r_cnt;
    assign w_map_msb = w_start ? msb_first : r_msb;

    bit_index_map #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_index_map (
        .i_cnt       (w_map_cnt),
        .i_msb_first (w_map_msb),
        .o_idx       (w_bit_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_start) begin
                    w_state_nxt = ST_SHIFT;
                end else if (w_bit && (r_cnt == c_LAST_IDX)) begin
`ifdef BIT_ORDER_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
            ST_PARITY: begin
                if (w_start) begin
                    w_state_nxt = ST_SHIFT;
                end else if (w_bit) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: when to store a data bit and when a frame completes
    always_comb begin
        w_capture = w_start || (w_bit && (r_state == ST_SHIFT));
`ifdef BIT_ORDER_PARITY_EN
        w_complete = w_bit && (r_state == ST_PARITY);
`else
        w_complete = w_bit && (r_state == ST_SHIFT) && (r_cnt == c_LAST_IDX);
`endif
    end

    // Shift register with the incoming bit dropped into its mapped position
    always_comb begin
        w_shift_nxt = w_start ? '0 : r_shift;
        for (int k = 0; k < WIDTH; k++) begin
            if (w_bit_idx == CNT_W'(k)) w_shift_nxt[k] = ser_data;
        end
    end

    // Without parity the word completes on its last data bit, so bypass the register
`ifdef BIT_ORDER_PARITY_EN
    assign w_word = r_shift;
`else
    assign w_word = w_shift_nxt;
`endif

    // Frame assembly: shift register, bit counter and latched order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_msb   <= LSB_FIRST;
        end else if (w_capture) begin
            r_shift <= w_shift_nxt;
            r_cnt   <= w_start ? CNT_W'(1) : r_cnt + CNT_W'(1);
            if (w_start) r_msb <= msb_first;
        end
    end

`ifdef BIT_ORDER_PARITY_EN
    logic r_parity_err;

    // Parity flag is loaded alongside the buffered word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else if (w_complete && (!r_out_valid || out_ready)) begin
            r_parity_err <= (^r_shift) ^ ser_data;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    // One-deep output buffer: load when free or draining, otherwise drop and flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (!r_out_valid || out_ready) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_word;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign overrun   = r_overrun;

endmodule : bit_order_deserializer

`default_nettype wire

// File: tb/tb_bit_order_deserializer.sv
// ============================================================================
//  Module      : tb_bit_order_deserializer
//  Description : Directed self-checking bench for bit_order_deserializer.
//                Define BIT_ORDER_PARITY_EN to also exercise the parity build.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_order_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_valid;
    logic       ser_data;
    logic       ser_start;
    logic       msb_first;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       overrun;
    logic       parity_err;

    int n_vec  = 0;
    int n_fail = 0;

    bit_order_deserializer #(
        .WIDTH (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_valid  (ser_valid),
        .ser_data   (ser_data),
        .ser_start  (ser_start),
        .msb_first  (msb_first),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one bit; it is consumed at the next rising edge, then return 1 ns later
    task automatic bit_in(input logic st, input logic d, input logic msb);
        ser_valid = 1'b1;
        ser_start = st;
        ser_data  = d;
        msb_first = msb;
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
        ser_start = 1'b0;
        ser_data  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bits[k] is the k-th bit in time; a trailing even-parity bit is added in the parity build
    task automatic send_frame(input logic [3:0] bits, input logic msb, input logic bad_par);
        for (int k = 0; k < 4; k++) bit_in(k == 0, bits[k], msb);
`ifdef BIT_ORDER_PARITY_EN
        bit_in(1'b0, (^bits) ^ bad_par, msb);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        ser_start = 1'b0;
        msb_first = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   32'(out_valid),  32'd0);
        chk("rst_data",    32'(out_data),   32'd0);
        chk("rst_overrun", 32'(overrun),    32'd0);
        chk("rst_perr",    32'(parity_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: LSB-first 1,0,1,1
        out_ready = 1'b1;
        send_frame(4'b1101, 1'b0, 1'b0);
        chk("t1_valid", 32'(out_valid),  32'd1);
        chk("t1_data",  32'(out_data),   32'hD);
        chk("t1_perr",  32'(parity_err), 32'd0);
        tick();
        chk("t1_valid_drop", 32'(out_valid), 32'd0);

        // 2: MSB-first, same bits
        send_frame(4'b1101, 1'b1, 1'b0);
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_data",  32'(out_data),  32'hB);
        tick();
        chk("t2_valid_drop", 32'(out_valid), 32'd0);

        // 3: stalled consumer, second word dropped
        out_ready = 1'b0;
        send_frame(4'b1100, 1'b0, 1'b0);
        chk("t3_valid_a",   32'(out_valid), 32'd1);
        chk("t3_data_a",    32'(out_data),  32'hC);
        chk("t3_overrun_a", 32'(overrun),   32'd0);
        send_frame(4'b1111, 1'b0, 1'b0);
        chk("t3_overrun_b", 32'(overrun),   32'd1);
        chk("t3_data_b",    32'(out_data),  32'hC);
        chk("t3_valid_b",   32'(out_valid), 32'd1);
        tick();
        chk("t3_overrun_pulse", 32'(overrun),   32'd0);
        chk("t3_valid_hold",    32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t3_valid_drop", 32'(out_valid), 32'd0);
        chk("t3_data_keep",  32'(out_data),  32'hC);

        // 4: restart after a 2-bit partial frame
        bit_in(1'b1, 1'b1, 1'b0);
        bit_in(1'b0, 1'b1, 1'b0);
        chk("t4_no_partial", 32'(out_valid), 32'd0);
        send_frame(4'b0110, 1'b0, 1'b0);
        chk("t4_valid", 32'(out_valid), 32'd1);
        chk("t4_data",  32'(out_data),  32'h6);
        tick();

        // 5: reset mid-frame with a full buffer
        out_ready = 1'b0;
        send_frame(4'b0101, 1'b0, 1'b0);
        chk("t5_full", 32'(out_valid), 32'd1);
        bit_in(1'b1, 1'b1, 1'b0);
        bit_in(1'b0, 1'b0, 1'b0);
        bit_in(1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid",   32'(out_valid), 32'd0);
        chk("t5_rst_data",    32'(out_data),  32'd0);
        chk("t5_rst_overrun", 32'(overrun),   32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        bit_in(1'b0, 1'b1, 1'b0);
        bit_in(1'b0, 1'b0, 1'b0);
        chk("t5_after_valid", 32'(out_valid), 32'd0);
        chk("t5_after_data",  32'(out_data),  32'd0);
        repeat (3) tick();
        chk("t5_idle_valid",   32'(out_valid),  32'd0);
        chk("t5_idle_overrun", 32'(overrun),    32'd0);
        chk("t5_idle_perr",    32'(parity_err), 32'd0);

`ifdef BIT_ORDER_PARITY_EN
        // 6: parity good then bad; bad word still delivered
        send_frame(4'b1101, 1'b0, 1'b0);
        chk("t6_good_valid", 32'(out_valid),  32'd1);
        chk("t6_good_data",  32'(out_data),   32'hD);
        chk("t6_good_perr",  32'(parity_err), 32'd0);
        tick();
        send_frame(4'b1101, 1'b0, 1'b1);
        chk("t6_bad_valid", 32'(out_valid),  32'd1);
        chk("t6_bad_data",  32'(out_data),   32'hD);
        chk("t6_bad_perr",  32'(parity_err), 32'd1);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_bit_order_deserializer

`default_nettype wire
